// File: rtl/circuito_jogo_param.sv
// Memory-game core: LFSR-generated button sequence, LED playback, press checking per round.
// Optional LED_ECO_EN: while waiting for a press, leds echo the buttons one cycle late.
module circuito_jogo_param #(
  parameter int          N_BOTOES    = 4,
  parameter int          DEPTH       = 16,
  parameter int          TIMEOUT_CYC = 3000,
  parameter int          SHOW_CYC    = 500,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       jogar,
  input  logic                       modo,
  input  logic [N_BOTOES-1:0]        botoes,
  output logic [N_BOTOES-1:0]        leds,
  output logic                       pronto,
  output logic                       ganhou,
  output logic                       perdeu,
  output logic                       timeout,
  output logic [$clog2(DEPTH)-1:0]   rodada,
  output logic [3:0]                 db_estado
);

  localparam int LB = $clog2(N_BOTOES);
  localparam int RW = $clog2(DEPTH);
  localparam int SW = $clog2(SHOW_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_CYC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] ULTIMA    = RW'(DEPTH - 1);

  localparam logic [3:0] INICIAL       = 4'd0;
  localparam logic [3:0] PREPARA       = 4'd1;
  localparam logic [3:0] MOSTRA_LED    = 4'd2;
  localparam logic [3:0] MOSTRA_PAUSA  = 4'd3;
  localparam logic [3:0] ESPERA_JOGADA = 4'd4;
  localparam logic [3:0] COMPARA       = 4'd5;
  localparam logic [3:0] PROXIMA       = 4'd6;
  localparam logic [3:0] FIM_GANHOU    = 4'd7;
  localparam logic [3:0] FIM_PERDEU    = 4'd8;

  logic [3:0]          estado;
  logic [15:0]         lfsr;
  logic [RW-1:0]       passo_idx;
  logic [RW-1:0]       ultimo_idx;
  logic [SW-1:0]       show_cnt;
  logic [TW-1:0]       to_cnt;
  logic [N_BOTOES-1:0] botoes_ant;
  logic [N_BOTOES-1:0] capturado;
  logic [N_BOTOES-1:0] passo;
  logic                modo_l;
  logic                por_timeout;
  logic                jogada;

  function automatic logic [15:0] lfsr_avanca(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // lfsr always holds the already-shifted value for the current step.
  always_comb begin
    passo = '0;
    passo[lfsr[LB-1:0]] = 1'b1;
  end

  assign ultimo_idx = modo_l ? ULTIMA : rodada;
  assign jogada     = (|botoes) && !(|botoes_ant);
  assign db_estado  = estado;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado      <= INICIAL;
      lfsr        <= SEED;
      passo_idx   <= '0;
      show_cnt    <= '0;
      to_cnt      <= '0;
      botoes_ant  <= '0;
      capturado   <= '0;
      modo_l      <= 1'b0;
      por_timeout <= 1'b0;
      rodada      <= '0;
    end else begin
      // Edge detector runs in every state so presses held from playback never count.
      botoes_ant <= botoes;
      case (estado)
        INICIAL: begin
          if (jogar) begin
            modo_l <= modo;
            estado <= PREPARA;
          end
        end
        PREPARA: begin
          rodada      <= '0;
          por_timeout <= 1'b0;
          passo_idx   <= '0;
          show_cnt    <= '0;
          lfsr        <= lfsr_avanca(SEED);
          estado      <= MOSTRA_LED;
        end
        MOSTRA_LED: begin
          if (show_cnt == SHOW_LAST) begin
            show_cnt <= '0;
            estado   <= MOSTRA_PAUSA;
          end else begin
            show_cnt <= show_cnt + 1'b1;
          end
        end
        MOSTRA_PAUSA: begin
          if (show_cnt == SHOW_LAST) begin
            show_cnt <= '0;
            if (passo_idx == ultimo_idx) begin
              passo_idx <= '0;
              lfsr      <= lfsr_avanca(SEED);
              to_cnt    <= '0;
              estado    <= ESPERA_JOGADA;
            end else begin
              passo_idx <= passo_idx + 1'b1;
              lfsr      <= lfsr_avanca(lfsr);
              estado    <= MOSTRA_LED;
            end
          end else begin
            show_cnt <= show_cnt + 1'b1;
          end
        end
        ESPERA_JOGADA: begin
          if (jogada) begin
            capturado <= botoes;
            estado    <= COMPARA;
          end else if (to_cnt == TO_LAST) begin
            por_timeout <= 1'b1;
            estado      <= FIM_PERDEU;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        COMPARA: begin
          // Equality with a one-hot value also rejects multi-button presses.
          if (capturado != passo) begin
            estado <= FIM_PERDEU;
          end else if (passo_idx == ultimo_idx) begin
            estado <= PROXIMA;
          end else begin
            passo_idx <= passo_idx + 1'b1;
            lfsr      <= lfsr_avanca(lfsr);
            to_cnt    <= '0;
            estado    <= ESPERA_JOGADA;
          end
        end
        PROXIMA: begin
          if (modo_l || rodada == ULTIMA) begin
            estado <= FIM_GANHOU;
          end else begin
            rodada    <= rodada + 1'b1;
            passo_idx <= '0;
            show_cnt  <= '0;
            lfsr      <= lfsr_avanca(SEED);
            estado    <= MOSTRA_LED;
          end
        end
        FIM_GANHOU, FIM_PERDEU: begin
          if (jogar) begin
            modo_l <= modo;
            estado <= PREPARA;
          end
        end
        default: estado <= INICIAL;
      endcase
    end
  end

  // Outputs follow the state register one cycle later.
  always_ff @(posedge clock) begin
    if (!reset) begin
      leds    <= '0;
      pronto  <= 1'b0;
      ganhou  <= 1'b0;
      perdeu  <= 1'b0;
      timeout <= 1'b0;
    end else begin
`ifdef LED_ECO_EN
      if (estado == MOSTRA_LED)
        leds <= passo;
      else if (estado == ESPERA_JOGADA)
        leds <= botoes;
      else
        leds <= '0;
`else
      leds <= (estado == MOSTRA_LED) ? passo : '0;
`endif
      pronto  <= (estado == FIM_GANHOU) || (estado == FIM_PERDEU);
      ganhou  <= (estado == FIM_GANHOU);
      perdeu  <= (estado == FIM_PERDEU);
      timeout <= (estado == FIM_PERDEU) && por_timeout;
    end
  end

endmodule

// File: tb/tb_circuito_jogo_param.sv
// Bench for circuito_jogo_param: random-timed play against a sequence-level game model.
module tb_circuito_jogo_param;
  localparam int NB = 4;
  localparam int DP = 4;
  localparam int TO = 50;
  localparam int SC = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          jogar = 1'b0;
  logic          modo  = 1'b0;
  logic [NB-1:0] botoes = '0;
  logic [NB-1:0] leds;
  logic          pronto, ganhou, perdeu, timeout;
  logic [1:0]    rodada;
  logic [3:0]    db_estado;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  circuito_jogo_param #(
    .N_BOTOES(NB), .DEPTH(DP), .TIMEOUT_CYC(TO), .SHOW_CYC(SC), .SEED(16'hACE1)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .modo(modo), .botoes(botoes),
    .leds(leds), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
    .timeout(timeout), .rodada(rodada), .db_estado(db_estado)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The game is described by its sequence (seq) plus how long each phase lasts.
  logic [NB-1:0] seq [DP];
  int            m_state = 0, m_t = 0, m_step = 0, m_rodada = 0;
  bit            m_modo = 0, m_to = 0, m_prev_any = 0;
  logic [NB-1:0] m_cap = '0;
  logic [NB-1:0] e_leds = '0;
  bit            e_pronto = 0, e_ganhou = 0, e_perdeu = 0, e_timeout = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic build_seq();
    logic [15:0] l;
    l = 16'hACE1;
    for (int k = 0; k < DP; k++) begin
      l = lfsr_next(l);
      seq[k] = NB'(1) << l[1:0];
    end
  endtask

  task automatic model_step();
    int  nsteps;
    int  nxt;
    bit  jog;
    if (!reset) begin
      m_state = 0; m_t = 0; m_step = 0; m_rodada = 0;
      m_modo = 0; m_to = 0; m_prev_any = 0; m_cap = '0;
      e_leds = '0; e_pronto = 0; e_ganhou = 0; e_perdeu = 0; e_timeout = 0;
      return;
    end
    e_leds    = (m_state == 2) ? seq[m_step] : '0;
    e_pronto  = (m_state == 7) || (m_state == 8);
    e_ganhou  = (m_state == 7);
    e_perdeu  = (m_state == 8);
    e_timeout = (m_state == 8) && m_to;
    nsteps = m_modo ? DP : m_rodada + 1;
    jog    = (|botoes) && !m_prev_any;
    nxt    = m_state;
    case (m_state)
      0, 7, 8: if (jogar) begin m_modo = modo; nxt = 1; end
      1: begin m_rodada = 0; m_to = 0; m_step = 0; nxt = 2; end
      2: if (m_t == SC - 1) nxt = 3;
      3: if (m_t == SC - 1) begin
           if (m_step == nsteps - 1) begin m_step = 0; nxt = 4; end
           else begin m_step++; nxt = 2; end
         end
      4: if (jog) begin m_cap = botoes; nxt = 5; end
         else if (m_t == TO - 1) begin m_to = 1; nxt = 8; end
      5: if (m_cap !== seq[m_step]) nxt = 8;
         else if (m_step == nsteps - 1) nxt = 6;
         else begin m_step++; nxt = 4; end
      6: if (m_modo || m_rodada == DP - 1) nxt = 7;
         else begin m_rodada++; m_step = 0; nxt = 2; end
      default: nxt = 0;
    endcase
    m_prev_any = |botoes;
    m_t = (nxt != m_state) ? 0 : m_t + 1;
    m_state = nxt;
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // ---------------- per-cycle scoreboard ----------------
  initial forever begin
    @(negedge clock);
    if (check_en) begin
      check("db_estado", 32'(db_estado), 32'(m_state));
      check("leds",      32'(leds),      32'(e_leds));
      check("pronto",    32'(pronto),    32'(e_pronto));
      check("ganhou",    32'(ganhou),    32'(e_ganhou));
      check("perdeu",    32'(perdeu),    32'(e_perdeu));
      check("timeout",   32'(timeout),   32'(e_timeout));
      check("rodada",    32'(rodada),    32'(m_rodada));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_state(input int s, input int budget, input bit noise);
    int n = 0;
    while (m_state != s && n < budget) begin
      if (noise && (m_state == 2 || m_state == 3))
        botoes = ($urandom_range(0, 2) == 0) ? NB'($urandom_range(0, 15)) : '0;
      tick();
      n++;
    end
    check($sformatf("wait_state_%0d", s), 32'(m_state), 32'(s));
  endtask

  task automatic wait_leds(input string name, input logic [NB-1:0] exp);
    int n = 0;
    while (leds == '0 && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(leds), 32'(exp));
  endtask

  task automatic press(input logic [NB-1:0] v);
    wait_state(4, 3000, 1'b1);
    botoes = '0;
    tick();
    botoes = v;
    repeat ($urandom_range(1, 10)) tick();
    botoes = '0;
    repeat ($urandom_range(1, 3)) tick();
  endtask

  task automatic start(input bit md);
    modo  = md;
    jogar = 1'b1;
    tick();
    jogar = 1'b0;
    check("start_prepara", 32'(db_estado), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NB-1:0] wrong;
    int n;
    build_seq();

    // Reset with jogar held, then leave reset still requesting a game.
    reset = 1'b0; jogar = 1'b1; modo = 1'b0;
    tick();
    check_en = 1'b1;
    check("rst_estado", 32'(db_estado), 32'd0);
    check("rst_leds",   32'(leds),      32'd0);
    check("rst_flags",  32'({pronto, ganhou, perdeu, timeout}), 32'd0);
    check("rst_rodada", 32'(rodada),    32'd0);
    reset = 1'b1;
    tick();
    jogar = 1'b0;
    check("leave_rst_prepara", 32'(db_estado), 32'd1);

    // Progressive win.
    wait_leds("first_led_m0", 4'b1000);
    for (int r = 0; r < DP; r++)
      for (int k = 0; k <= r; k++)
        press(seq[k]);
    wait_state(7, 500, 1'b0);
    tick();
    check("win_ganhou", 32'(ganhou), 32'd1);
    check("win_pronto", 32'(pronto), 32'd1);
    check("win_perdeu", 32'(perdeu), 32'd0);
    check("win_rodada", 32'(rodada), 32'd3);

    // Wrong one-hot press on round 2, step index 1.
    start(1'b0);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k <= r; k++)
        press(seq[k]);
    press(seq[0]);
    wait_state(4, 3000, 1'b1);
    botoes = '0;
    tick();
    wrong = {seq[1][NB-2:0], seq[1][NB-1]};
    botoes = wrong;
    repeat (3) tick();
    check("wrong_perdeu",  32'(perdeu),  32'd1);
    check("wrong_timeout", 32'(timeout), 32'd0);
    check("wrong_rodada",  32'(rodada),  32'd2);
    botoes = '0;
    tick();

    // Timeout: no press at all in round 0.
    start(1'b0);
    wait_state(4, 500, 1'b0);
    botoes = '0;
    n = 0;
    while (db_estado != 4'd8 && n < 200) begin
      tick();
      n++;
    end
    check("timeout_latency", 32'(n), 32'd50);
    tick();
    check("timeout_flag", 32'(timeout), 32'd1);
    check("timeout_perdeu", 32'(perdeu), 32'd1);

    // Button held across end of playback does not count; then an invalid two-button press.
    start(1'b0);
    wait_state(3, 500, 1'b0);
    botoes = seq[0];
    wait_state(4, 500, 1'b0);
    repeat (5) tick();
    check("held_no_jogada", 32'(db_estado), 32'd4);
    botoes = '0;
    tick();
    botoes = 4'b0011;
    repeat (3) tick();
    check("invalid_perdeu",  32'(perdeu),  32'd1);
    check("invalid_timeout", 32'(timeout), 32'd0);
    botoes = '0;
    tick();

    // Single-round mode, played twice: the sequence must repeat.
    for (int g = 0; g < 2; g++) begin
      start(1'b1);
      wait_leds("first_led_m1", 4'b1000);
      for (int k = 0; k < DP; k++)
        press(seq[k]);
      wait_state(7, 500, 1'b0);
      tick();
      check("m1_ganhou", 32'(ganhou), 32'd1);
      check("m1_rodada", 32'(rodada), 32'd0);
    end

    // Reset in the middle of playback.
    start(1'b0);
    wait_leds("first_led_rst", 4'b1000);
    reset = 1'b0;
    tick();
    check("midrst_estado", 32'(db_estado), 32'd0);
    check("midrst_leds",   32'(leds),      32'd0);
    reset = 1'b1;
    repeat (3) tick();
    check("midrst_idle", 32'(db_estado), 32'd0);

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
